fixed_decoder: RTL and testbench
================================

# fixed_decoder

Inverse of the fixed-order FLAC encoder. It takes a stream of residual words, reconstructed sample by sample, and rebuilds the original signed PCM samples for one block. The block supports predictor orders 0–4, including order 2, which matches the encoder's `residual = x[n] - 2x[n-1] + x[n-2]`. It sits after the residual (Rice) decoder and before the PCM output buffer in the hardware decode path.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 16: signed sample width.
- `RES_WIDTH`, 20: signed residual width. Must be at least SAMPLE_WIDTH+4 so order-4 residuals fit.

Ports:
- `iClock`, in, 1: single clock; all logic on the rising edge.
- `iReset`, in, 1: synchronous, active-high reset.
- `iStart`, in, 1: one-cycle pulse that begins a block; latches `iOrder` and `iBlockSize`.
- `iOrder`, in, 3: predictor order 0–4.
- `iBlockSize`, in, 16: number of samples in the block, at least 1.
- `iEnable`, in, 1: `iResidual` holds a valid word this cycle.
- `iResidual`, in, RES_WIDTH: a warm-up sample (sign-extended) or a residual.
- `oSample`, out, SAMPLE_WIDTH: reconstructed sample.
- `oValid`, out, 1: `oSample` is valid this cycle.
- `oDone`, out, 1: one-cycle pulse, coincident with `oValid` of the last sample of the block.
- `oBusy`, out, 1: high in WARMUP and DECODE.

## Operation
- The state machine is IDLE → WARMUP → DECODE → IDLE.
- **IDLE:**
  - `iStart` with `iOrder` ≤ 4 and `iBlockSize` ≠ 0 latches both, clears the history and the sample counter, and moves to WARMUP.
  - Order 0 goes directly to DECODE.
  - An invalid order (5–7) or a block size of 0 is ignored; the block stays in IDLE.
  - `iEnable` is ignored in IDLE.
- **WARMUP:** the first `order` accepted words are verbatim samples.
  - The output is the low SAMPLE_WIDTH bits of `iResidual`.
  - Each word is pushed into the history.
  - After `order` words, the state moves to DECODE.
- **DECODE:** each accepted word produces `sample = residual + pred`, where `x1..x4` are the most recent outputs:
  - order 0: pred = 0
  - order 1: pred = x1
  - order 2: pred = 2·x1 − x2
  - order 3: pred = 3·x1 − 3·x2 + x3
  - order 4: pred = 4·x1 − 6·x2 + 4·x3 − x4
- **Arithmetic:**
  - The prediction and the sum are computed at RES_WIDTH+4 bits, signed.
  - The result is truncated to SAMPLE_WIDTH, wrapping two's-complement with no saturation.
  - The truncated value is both the output and the new x1.
- **Counter:**
  - Counts accepted words in both WARMUP and DECODE.
  - On word number `iBlockSize`, assert `oDone` with the output and return to IDLE.
  - If `iBlockSize` ≤ order, every word is warm-up and the block ends in WARMUP.
- **Simultaneous events:**
  - `iStart` asserted in WARMUP or DECODE aborts the current block and restarts. No `oDone` is issued.
  - If `iEnable` is also high in that cycle, its word is dropped.
  - After the last word, the block is back in IDLE on the next cycle; an `iStart` in that cycle is accepted.
- **Reset:**
  - Asserting `iReset` (including mid-block) returns to IDLE and clears the history, counter, and latched order and size.
  - `oSample`, `oValid`, `oDone`, and `oBusy` all reset to 0.

## Timing
- Latency is 1 cycle: a word accepted on edge n produces `oSample` and `oValid` after edge n, with the history updated on the same edge.
- Full throughput of one word per cycle, back-to-back. There is no backpressure and no stall.
- `oValid` is a registered copy of the accepted `iEnable`. `oSample` holds its last value when `oValid` = 0.
- `oBusy` goes high the cycle after an accepted `iStart`. It goes low the cycle after the last word is accepted, the same cycle `oDone` and the last `oValid` are high.

## Structure
- Package `fixed_decoder_pkg` holds:
  - the state enum (IDLE, WARMUP, DECODE);
  - `MAX_ORDER` = 4;
  - order constants;
  - the coefficient rows, or `GUARD_BITS` = 4 for widening.
- Sub-module `fixed_predictor`: combinational, taking `x1..x4` and the order and producing a widened signed `pred`. It is shared with the encoder regression model.
- The top level contains the FSM, the counter, the four-deep history shift register, and the output registers.

## Test plan
- **Order 2 round-trip:**
  - Stimulus: `iStart` with order 2 and size 10, then words 20, 10, −7, 20, 9, −20, 10, −7, 9, −5 back-to-back.
  - Required: outputs 20, 10, −7, −4, 8, 0, 2, −3, 1, 0 with a 1-cycle lag, `oDone` on the last output, then `oBusy` = 0.
- **Orders 0, 1, 4:**
  - order 0, words 7, −3 → 7, −3;
  - order 1, words 5, 3, −2 → 5, 8, 6;
  - order 4, words 1, 2, 3, 4, 0 → 1, 2, 3, 4, 5.
- **Gapped input and wrap:**
  - Stimulus: order 1, size 3, words 32767, 1, 0, with `iEnable` toggled so there are idle cycles between words.
  - Required: outputs 32767, −32768, −32768; `oValid` only on accept cycles.
- **Short block:**
  - Stimulus: order 3, size 2, words 4, 9.
  - Required: outputs 4, 9, `oDone` on 9, and the block never enters DECODE.
- **Abort and reset:**
  - `iStart` with order 2 mid-block (while `iEnable` is high) → that word is dropped, no `oDone`, and the fresh block decodes correctly.
  - `iReset` mid-block → all outputs 0 on the next cycle, and the next block decodes correctly.
- **Illegal start:**
  - Stimulus: `iStart` with order 6, or with size 0.
  - Required: `oBusy` stays 0, and subsequent words produce no `oValid`.

Source files
------------

// File: rtl/fixed_decoder_pkg.sv
// Shared types and constants for the fixed-order FLAC residual decoder
// and its predictor.
package fixed_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_DECODE
    } state_e;

    localparam int MAX_ORDER  = 4;
    localparam int GUARD_BITS = 4;

    localparam logic [2:0] ORDER_0 = 3'd0;
    localparam logic [2:0] ORDER_1 = 3'd1;
    localparam logic [2:0] ORDER_2 = 3'd2;
    localparam logic [2:0] ORDER_3 = 3'd3;
    localparam logic [2:0] ORDER_4 = 3'd4;

endpackage

// File: rtl/fixed_decoder_if.sv
// Block-control and sample-stream bundle between the Rice decoder,
// the fixed-order decoder and the PCM output buffer.
interface fixed_decoder_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int RES_WIDTH    = 20
);
    logic                           iStart;
    logic [2:0]                     iOrder;
    logic [15:0]                    iBlockSize;
    logic                           iEnable;
    logic signed [RES_WIDTH-1:0]    iResidual;
    logic signed [SAMPLE_WIDTH-1:0] oSample;
    logic                           oValid;
    logic                           oDone;
    logic                           oBusy;

    modport master (
        output iStart, iOrder, iBlockSize, iEnable, iResidual,
        input  oSample, oValid, oDone, oBusy
    );

    modport slave (
        input  iStart, iOrder, iBlockSize, iEnable, iResidual,
        output oSample, oValid, oDone, oBusy
    );
endinterface

// File: rtl/fixed_predictor.sv
// Combinational fixed-order FLAC predictor: weighted sum of the last four
// samples, widened so no intermediate term can overflow.
module fixed_predictor
    import fixed_decoder_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int PRED_WIDTH   = 24
) (
    input  logic [2:0]                     order_i,
    input  logic signed [SAMPLE_WIDTH-1:0] x1_i,
    input  logic signed [SAMPLE_WIDTH-1:0] x2_i,
    input  logic signed [SAMPLE_WIDTH-1:0] x3_i,
    input  logic signed [SAMPLE_WIDTH-1:0] x4_i,
    output logic signed [PRED_WIDTH-1:0]   pred_o
);

    logic signed [PRED_WIDTH-1:0] e1, e2, e3, e4;

    assign e1 = PRED_WIDTH'(x1_i);
    assign e2 = PRED_WIDTH'(x2_i);
    assign e3 = PRED_WIDTH'(x3_i);
    assign e4 = PRED_WIDTH'(x4_i);

    always_comb begin
        pred_o = '0;
        case (order_i)
            ORDER_1: pred_o = e1;
            ORDER_2: pred_o = (e1 <<< 1) - e2;
            ORDER_3: pred_o = (e1 <<< 1) + e1 - (e2 <<< 1) - e2 + e3;
            ORDER_4: pred_o = (e1 <<< 2) - (e2 <<< 2) - (e2 <<< 1) + (e3 <<< 2) - e4;
            default: pred_o = '0;
        endcase
    end

endmodule

// File: rtl/fixed_decoder.sv
// Fixed-order FLAC decoder: turns warm-up samples and residuals back into
// signed PCM samples for one block, one word per cycle, one cycle latency.
module fixed_decoder
    import fixed_decoder_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int RES_WIDTH    = 20
) (
    input  logic          iClock,
    input  logic          iReset,
    fixed_decoder_if.slave bus
);

    localparam int EXT_WIDTH = RES_WIDTH + GUARD_BITS;

    state_e                         state_q, state_d;
    logic [2:0]                     order_q, order_d;
    logic [15:0]                    size_q, size_d;
    logic [15:0]                    cnt_q, cnt_d;
    logic [15:0]                    cnt_next;
    logic signed [SAMPLE_WIDTH-1:0] hist_q [4];
    logic signed [SAMPLE_WIDTH-1:0] hist_d [4];
    logic signed [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                           valid_q, valid_d;
    logic                           done_q, done_d;
    logic signed [EXT_WIDTH-1:0]    pred;
    logic signed [SAMPLE_WIDTH-1:0] word;
    logic                           start_ok;

    fixed_predictor #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .PRED_WIDTH   (EXT_WIDTH)
    ) u_pred (
        .order_i (order_q),
        .x1_i    (hist_q[0]),
        .x2_i    (hist_q[1]),
        .x3_i    (hist_q[2]),
        .x4_i    (hist_q[3]),
        .pred_o  (pred)
    );

    assign start_ok = bus.iStart && (bus.iOrder <= 3'(MAX_ORDER)) && (bus.iBlockSize != '0);
    assign cnt_next = cnt_q + 16'd1;
    // Wrap to sample width: warm-up words are verbatim, others add the prediction.
    assign word = (state_q == ST_WARMUP) ? SAMPLE_WIDTH'(bus.iResidual)
                                         : SAMPLE_WIDTH'(EXT_WIDTH'(bus.iResidual) + pred);

    always_comb begin
        state_d  = state_q;
        order_d  = order_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        hist_d   = hist_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;

        if (state_q == ST_IDLE || bus.iStart) begin
            // A start in an active block aborts it; any word in that cycle is dropped.
            if (bus.iStart) begin
                state_d = ST_IDLE;
                if (start_ok) begin
                    order_d = bus.iOrder;
                    size_d  = bus.iBlockSize;
                    cnt_d   = '0;
                    for (int unsigned i = 0; i < 4; i++) hist_d[i] = '0;
                    state_d = (bus.iOrder == ORDER_0) ? ST_DECODE : ST_WARMUP;
                end
            end
        end else if (bus.iEnable) begin
            sample_d  = word;
            valid_d   = 1'b1;
            hist_d[3] = hist_q[2];
            hist_d[2] = hist_q[1];
            hist_d[1] = hist_q[0];
            hist_d[0] = word;
            cnt_d     = cnt_next;
            if (cnt_next == size_q) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else if (state_q == ST_WARMUP && cnt_next == {13'd0, order_q}) begin
                state_d = ST_DECODE;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q  <= ST_IDLE;
            order_q  <= '0;
            size_q   <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < 4; i++) hist_q[i] <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            order_q  <= order_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
            hist_q   <= hist_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign bus.oSample = sample_q;
    assign bus.oValid  = valid_q;
    assign bus.oDone   = done_q;
    assign bus.oBusy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fixed_decoder.sv
// Directed self-checking bench for fixed_decoder.
module tb_fixed_decoder;

    localparam int SW = 16;
    localparam int RW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fixed_decoder_if #(.SAMPLE_WIDTH(SW), .RES_WIDTH(RW)) bus ();

    fixed_decoder #(.SAMPLE_WIDTH(SW), .RES_WIDTH(RW)) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [2:0] ord, input logic [15:0] sz);
        bus.iStart     = 1'b1;
        bus.iOrder     = ord;
        bus.iBlockSize = sz;
        bus.iEnable    = 1'b0;
        tick();
        bus.iStart     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.oSample !== 16'sd0) begin bad++; $display("FAIL reset_sample got=%0d exp=0", bus.oSample); end
        total++; if (bus.oValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.oValid); end
        total++; if (bus.oDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.oDone); end
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.oBusy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_order2();
        int w[10] = '{20, 10, -7, 20, 9, -20, 10, -7, 9, -5};
        int e[10] = '{20, 10, -7, -4, 8, 0, 2, -3, 1, 0};
        start_block(3'd2, 16'd10);
        total++; if (bus.oBusy !== 1'b1) begin bad++; $display("FAIL o2_busy_start got=%b exp=1", bus.oBusy); end
        for (int i = 0; i < 10; i++) begin
            bus.iEnable = 1'b1; bus.iResidual = RW'(w[i]);
            tick();
            total++; if (bus.oValid !== 1'b1 || bus.oSample !== SW'(e[i])) begin
                bad++; $display("FAIL o2_sample[%0d] got=%0d/v%b exp=%0d/v1", i, bus.oSample, bus.oValid, e[i]);
            end
            total++; if (bus.oDone !== (i == 9) || bus.oBusy !== (i != 9)) begin
                bad++; $display("FAIL o2_flags[%0d] got=done%b busy%b exp=done%b busy%b", i, bus.oDone, bus.oBusy, i == 9, i != 9);
            end
        end
        bus.iEnable = 1'b0;
        tick();
        total++; if (bus.oValid !== 1'b0 || bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) begin
            bad++; $display("FAIL o2_after got=v%b d%b b%b exp=000", bus.oValid, bus.oDone, bus.oBusy);
        end
    endtask

    task automatic test_orders();
        logic [2:0] ord[3] = '{3'd0, 3'd1, 3'd4};
        int sz[3] = '{2, 3, 5};
        int w[3][5] = '{'{7, -3, 0, 0, 0}, '{5, 3, -2, 0, 0}, '{1, 2, 3, 4, 0}};
        int e[3][5] = '{'{7, -3, 0, 0, 0}, '{5, 8, 6, 0, 0}, '{1, 2, 3, 4, 5}};
        for (int c = 0; c < 3; c++) begin
            start_block(ord[c], 16'(sz[c]));
            for (int i = 0; i < sz[c]; i++) begin
                bus.iEnable = 1'b1; bus.iResidual = RW'(w[c][i]);
                tick();
                total++; if (bus.oValid !== 1'b1 || bus.oSample !== SW'(e[c][i]) || bus.oDone !== (i == sz[c] - 1)) begin
                    bad++; $display("FAIL ord%0d[%0d] got=%0d/v%b/d%b exp=%0d/v1/d%b", ord[c], i, bus.oSample, bus.oValid, bus.oDone, e[c][i], i == sz[c] - 1);
                end
            end
            bus.iEnable = 1'b0;
            tick();
            total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL ord%0d_busy_end got=%b exp=0", ord[c], bus.oBusy); end
        end
    endtask

    task automatic test_gapped_wrap();
        int w[3] = '{32767, 1, 0};
        int e[3] = '{32767, -32768, -32768};
        start_block(3'd1, 16'd3);
        for (int i = 0; i < 3; i++) begin
            bus.iEnable = 1'b1; bus.iResidual = RW'(w[i]);
            tick();
            total++; if (bus.oValid !== 1'b1 || bus.oSample !== SW'(e[i])) begin
                bad++; $display("FAIL wrap[%0d] got=%0d/v%b exp=%0d/v1", i, bus.oSample, bus.oValid, e[i]);
            end
            bus.iEnable = 1'b0; bus.iResidual = RW'(12345);
            tick();
            total++; if (bus.oValid !== 1'b0 || bus.oSample !== SW'(e[i])) begin
                bad++; $display("FAIL wrap_gap[%0d] got=%0d/v%b exp=%0d/v0", i, bus.oSample, bus.oValid, e[i]);
            end
        end
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL wrap_busy_end got=%b exp=0", bus.oBusy); end
    endtask

    task automatic test_short_block();
        start_block(3'd3, 16'd2);
        bus.iEnable = 1'b1; bus.iResidual = RW'(4);
        tick();
        total++; if (bus.oSample !== 16'sd4 || bus.oDone !== 1'b0 || bus.oBusy !== 1'b1) begin
            bad++; $display("FAIL short_first got=%0d/d%b/b%b exp=4/d0/b1", bus.oSample, bus.oDone, bus.oBusy);
        end
        bus.iResidual = RW'(9);
        tick();
        total++; if (bus.oSample !== 16'sd9 || bus.oDone !== 1'b1 || bus.oBusy !== 1'b0) begin
            bad++; $display("FAIL short_last got=%0d/d%b/b%b exp=9/d1/b0", bus.oSample, bus.oDone, bus.oBusy);
        end
        bus.iResidual = RW'(1);
        tick();
        total++; if (bus.oValid !== 1'b0) begin bad++; $display("FAIL short_after got=%b exp=0", bus.oValid); end
        bus.iEnable = 1'b0;
    endtask

    task automatic test_abort();
        int w[3] = '{5, 6, 0};
        int e[3] = '{5, 6, 7};
        start_block(3'd2, 16'd10);
        bus.iEnable = 1'b1; bus.iResidual = RW'(20);
        tick();
        bus.iResidual = RW'(10);
        tick();
        bus.iStart = 1'b1; bus.iOrder = 3'd2; bus.iBlockSize = 16'd3; bus.iResidual = RW'(99);
        tick();
        bus.iStart = 1'b0;
        total++; if (bus.oValid !== 1'b0 || bus.oDone !== 1'b0 || bus.oBusy !== 1'b1) begin
            bad++; $display("FAIL abort_drop got=v%b d%b b%b exp=v0 d0 b1", bus.oValid, bus.oDone, bus.oBusy);
        end
        for (int i = 0; i < 3; i++) begin
            bus.iResidual = RW'(w[i]);
            tick();
            total++; if (bus.oValid !== 1'b1 || bus.oSample !== SW'(e[i]) || bus.oDone !== (i == 2)) begin
                bad++; $display("FAIL abort_new[%0d] got=%0d/v%b/d%b exp=%0d/v1/d%b", i, bus.oSample, bus.oValid, bus.oDone, e[i], i == 2);
            end
        end
        bus.iEnable = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        start_block(3'd1, 16'd5);
        bus.iEnable = 1'b1; bus.iResidual = RW'(3);
        tick();
        bus.iResidual = RW'(4);
        tick();
        total++; if (bus.oSample !== 16'sd7) begin bad++; $display("FAIL rmid_pre got=%0d exp=7", bus.oSample); end
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.iEnable = 1'b0;
        total++; if (bus.oSample !== 16'sd0 || bus.oValid !== 1'b0 || bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) begin
            bad++; $display("FAIL rmid_clear got=%0d/v%b/d%b/b%b exp=0/v0/d0/b0", bus.oSample, bus.oValid, bus.oDone, bus.oBusy);
        end
        start_block(3'd1, 16'd2);
        bus.iEnable = 1'b1; bus.iResidual = RW'(1);
        tick();
        tick();
        total++; if (bus.oSample !== 16'sd2 || bus.oDone !== 1'b1) begin
            bad++; $display("FAIL rmid_next got=%0d/d%b exp=2/d1", bus.oSample, bus.oDone);
        end
        bus.iEnable = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        start_block(3'd6, 16'd4);
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL ill_order_busy got=%b exp=0", bus.oBusy); end
        bus.iEnable = 1'b1; bus.iResidual = RW'(5);
        tick();
        total++; if (bus.oValid !== 1'b0) begin bad++; $display("FAIL ill_order_valid got=%b exp=0", bus.oValid); end
        start_block(3'd2, 16'd0);
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL ill_size_busy got=%b exp=0", bus.oBusy); end
        bus.iEnable = 1'b1; bus.iResidual = RW'(5);
        tick();
        total++; if (bus.oValid !== 1'b0) begin bad++; $display("FAIL ill_size_valid got=%b exp=0", bus.oValid); end
        bus.iEnable = 1'b0;
    endtask

    task automatic test_back_to_back();
        start_block(3'd0, 16'd1);
        bus.iEnable = 1'b1; bus.iResidual = RW'(8);
        tick();
        total++; if (bus.oSample !== 16'sd8 || bus.oDone !== 1'b1 || bus.oBusy !== 1'b0) begin
            bad++; $display("FAIL b2b_first got=%0d/d%b/b%b exp=8/d1/b0", bus.oSample, bus.oDone, bus.oBusy);
        end
        start_block(3'd1, 16'd2);
        total++; if (bus.oBusy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%b exp=1", bus.oBusy); end
        bus.iEnable = 1'b1; bus.iResidual = RW'(2);
        tick();
        bus.iResidual = RW'(3);
        tick();
        total++; if (bus.oSample !== 16'sd5 || bus.oDone !== 1'b1) begin
            bad++; $display("FAIL b2b_second got=%0d/d%b exp=5/d1", bus.oSample, bus.oDone);
        end
        bus.iEnable = 1'b0;
        tick();
    endtask

    initial begin
        bus.iStart     = 1'b0;
        bus.iOrder     = '0;
        bus.iBlockSize = '0;
        bus.iEnable    = 1'b0;
        bus.iResidual  = '0;
        test_reset();
        test_order2();
        test_orders();
        test_gapped_wrap();
        test_short_block();
        test_abort();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
